// File: rtl/text_renderer_8x8_if.sv
// rtl/text_renderer_8x8_if.sv - pixel, text RAM, font and video output signal bundle
interface text_renderer_8x8_if #(
    parameter int X_W    = 10,
    parameter int Y_W    = 10,
    parameter int ADDR_W = 12,
    parameter int RGB_W  = 12
) ();
    logic [X_W-1:0]    px_x;
    logic [Y_W-1:0]    px_y;
    logic              de_in;
    logic              hsync_in;
    logic              vsync_in;
    logic [ADDR_W-1:0] tx_addr;
    logic [7:0]        tx_data;
    logic [7:0]        char_code;
    logic [63:0]       glyph;
    logic              cursor_en;
    logic [6:0]        cursor_col;
    logic [4:0]        cursor_row;
    logic [RGB_W-1:0]  rgb;
    logic              hsync_out;
    logic              vsync_out;
    logic              de_out;

    modport slave (
        input  px_x, px_y, de_in, hsync_in, vsync_in, tx_data, glyph,
               cursor_en, cursor_col, cursor_row,
        output tx_addr, char_code, rgb, hsync_out, vsync_out, de_out
    );

    modport master (
        output px_x, px_y, de_in, hsync_in, vsync_in, tx_data, glyph,
               cursor_en, cursor_col, cursor_row,
        input  tx_addr, char_code, rgb, hsync_out, vsync_out, de_out
    );
endinterface

// File: rtl/text_renderer_8x8.sv
// rtl/text_renderer_8x8.sv - 3-stage 8x8 text-mode pixel pipeline with blinking cursor
module text_renderer_8x8 #(
    parameter int               COLS      = 80,
    parameter int               ROWS      = 30,
    parameter int               X_W       = 10,
    parameter int               Y_W       = 10,
    parameter int               ADDR_W    = 12,
    parameter int               RGB_W     = 12,
    parameter logic [RGB_W-1:0] FG        = 12'hFFF,
    parameter logic [RGB_W-1:0] BG        = 12'h000,
    parameter int               BLINK_BIT = 4
) (
    input  logic               clk,
    input  logic               resetn,
    text_renderer_8x8_if.slave bus
);
    localparam int CW = X_W - 3;
    localparam int RW = Y_W - 3;

    // Cell decode on the raw timing-generator inputs
    logic [CW-1:0]     col;
    logic [RW-1:0]     row;
    logic [2:0]        bx;
    logic [2:0]        by;
    logic              oob_d;
    logic              hit_d;
    logic [ADDR_W-1:0] addr_d;

    assign col    = bus.px_x[X_W-1:3];
    assign row    = bus.px_y[Y_W-1:3];
    assign bx     = bus.px_x[2:0];
    assign by     = bus.px_y[2:0];
    assign oob_d  = (col >= CW'(COLS)) | (row >= RW'(ROWS));
    assign hit_d  = bus.cursor_en & (col == CW'(bus.cursor_col))
                  & (row == RW'(bus.cursor_row)) & by[2] & by[1];
    assign addr_d = ADDR_W'(row) * ADDR_W'(COLS) + ADDR_W'(col);

    logic [ADDR_W-1:0] addr_q;
    logic [2:0]        bx1_q, by1_q, bx2_q, by2_q;
    logic              oob1_q, de1_q, hs1_q, vs1_q, hit1_q;
    logic              oob2_q, de2_q, hs2_q, vs2_q, hit2_q;
    logic [RGB_W-1:0]  rgb_q;
    logic              hs3_q, vs3_q, de3_q;
    logic              vs_prev_q;
    logic [BLINK_BIT:0] frame_q;

    // Stage 1 issues the RAM address; stage 2 holds the sideband while RAM data arrives
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            addr_q <= '0;
            bx1_q  <= '0;  by1_q <= '0;  oob1_q <= 1'b0;  de1_q <= 1'b0;
            hs1_q  <= 1'b0; vs1_q <= 1'b0; hit1_q <= 1'b0;
            bx2_q  <= '0;  by2_q <= '0;  oob2_q <= 1'b0;  de2_q <= 1'b0;
            hs2_q  <= 1'b0; vs2_q <= 1'b0; hit2_q <= 1'b0;
        end else begin
            addr_q <= addr_d;
            bx1_q  <= bx;        by1_q <= by;         oob1_q <= oob_d;
            de1_q  <= bus.de_in; hs1_q <= bus.hsync_in;
            vs1_q  <= bus.vsync_in; hit1_q <= hit_d;
            bx2_q  <= bx1_q;     by2_q <= by1_q;      oob2_q <= oob1_q;
            de2_q  <= de1_q;     hs2_q <= hs1_q;      vs2_q  <= vs1_q;
            hit2_q <= hit1_q;
        end
    end

    // Glyph bit select: row by lives in byte (7-by), pixel bx at bit (7-bx) of that byte
    logic             gbit;
    logic             blink_on;
    logic             on_d;
    logic [RGB_W-1:0] rgb_d;

    assign gbit     = bus.glyph[{~by2_q, ~bx2_q}];
    assign blink_on = frame_q[BLINK_BIT];
    assign on_d     = (gbit | (hit2_q & blink_on)) & ~oob2_q;
    assign rgb_d    = de2_q ? (on_d ? FG : BG) : '0;

    // Stage 3 registers the pixel colour and the aligned sync/enable
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            rgb_q <= '0;
            hs3_q <= 1'b0;
            vs3_q <= 1'b0;
            de3_q <= 1'b0;
        end else begin
            rgb_q <= rgb_d;
            hs3_q <= hs2_q;
            vs3_q <= vs2_q;
            de3_q <= de2_q;
        end
    end

    // Frame counter advances on each vsync_in rising edge and wraps freely
    logic               vs_rise;
    logic [BLINK_BIT:0] frame_d;

    assign vs_rise = bus.vsync_in & ~vs_prev_q;
    assign frame_d = frame_q + {{BLINK_BIT{1'b0}}, vs_rise};

    // Blink state registers
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            vs_prev_q <= 1'b0;
            frame_q   <= '0;
        end else begin
            vs_prev_q <= bus.vsync_in;
            frame_q   <= frame_d;
        end
    end

    assign bus.tx_addr   = addr_q;
    assign bus.char_code = bus.tx_data;
    assign bus.rgb       = rgb_q;
    assign bus.hsync_out = hs3_q;
    assign bus.vsync_out = vs3_q;
    assign bus.de_out    = de3_q;
endmodule

// File: tb/tb_text_renderer_8x8.sv
// tb/tb_text_renderer_8x8.sv - self-checking bench for text_renderer_8x8
module tb_text_renderer_8x8;
    localparam logic [11:0] FG = 12'hFFF;
    localparam logic [11:0] BG = 12'h000;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    always #5 clk = ~clk;

    text_renderer_8x8_if bus ();
    text_renderer_8x8 dut (.clk(clk), .resetn(resetn), .bus(bus.slave));

    logic [7:0]  ram  [4096];
    logic [63:0] font [256];

    always @(posedge clk) bus.tx_data <= ram[bus.tx_addr];
    assign bus.glyph = font[bus.char_code];

    typedef struct {
        int px; int py; bit de; bit hs; bit vs; bit cen; int ccol; int crow;
    } samp_t;

    typedef struct {
        int px; int py; bit de; logic [11:0] exp;
    } vec_t;

    samp_t hist[$];
    int    cnt_m;
    bit    prev_vs;
    int    n_chk;
    int    n_fail;

    function automatic samp_t mk(int px, int py, bit de, bit hs, bit vs, bit cen, int ccol, int crow);
        samp_t s;
        s.px = px; s.py = py; s.de = de; s.hs = hs; s.vs = vs;
        s.cen = cen; s.ccol = ccol; s.crow = crow;
        return s;
    endfunction

    function automatic logic [11:0] ref_rgb(samp_t s, int cnt);
        int col, row, bx, by, addr;
        bit oob, gbit, hit, blink, on;
        logic [63:0] g;
        col   = s.px / 8;
        row   = s.py / 8;
        bx    = s.px % 8;
        by    = s.py % 8;
        oob   = (col >= 80) || (row >= 30);
        addr  = (row * 80 + col) % 4096;
        g     = font[ram[addr]];
        gbit  = g[63 - 8 * by - bx];
        hit   = s.cen && (col == s.ccol) && (row == s.crow) && (by >= 6);
        blink = ((cnt / 16) % 2) == 1;
        on    = (gbit || (hit && blink)) && !oob;
        if (!s.de) return 12'h000;
        return on ? FG : BG;
    endfunction

    task automatic check(string name, logic [63:0] act, logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step(input samp_t s, output logic [11:0] o_rgb, output logic o_hs);
        samp_t e;
        bus.px_x       = 10'(s.px);
        bus.px_y       = 10'(s.py);
        bus.de_in      = s.de;
        bus.hsync_in   = s.hs;
        bus.vsync_in   = s.vs;
        bus.cursor_en  = s.cen;
        bus.cursor_col = 7'(s.ccol);
        bus.cursor_row = 5'(s.crow);
        hist.push_back(s);
        @(posedge clk);
        #1;
        e = hist.pop_front();
        check("rgb", 64'(bus.rgb), 64'(ref_rgb(e, cnt_m)));
        check("hsync_out", 64'(bus.hsync_out), 64'(e.hs));
        check("vsync_out", 64'(bus.vsync_out), 64'(e.vs));
        check("de_out", 64'(bus.de_out), 64'(e.de));
        o_rgb = bus.rgb;
        o_hs  = bus.hsync_out;
        if (s.vs && !prev_vs) cnt_m++;
        prev_vs = s.vs;
    endtask

    task automatic probe(input samp_t s, output logic [11:0] o_rgb, output logic o_hs);
        samp_t idle;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0);
        step(s, o_rgb, o_hs);
        step(idle, o_rgb, o_hs);
        step(idle, o_rgb, o_hs);
    endtask

    task automatic do_reset(int cycles);
        samp_t z;
        resetn = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            bus.px_x     = 10'($urandom);
            bus.px_y     = 10'($urandom);
            bus.de_in    = 1'($urandom);
            bus.hsync_in = 1'($urandom);
            bus.vsync_in = 1'($urandom);
            @(posedge clk);
            #1;
            check("rst_rgb", 64'(bus.rgb), 64'h0);
            check("rst_hs", 64'(bus.hsync_out), 64'h0);
            check("rst_vs", 64'(bus.vsync_out), 64'h0);
            check("rst_de", 64'(bus.de_out), 64'h0);
            check("rst_addr", 64'(bus.tx_addr), 64'h0);
        end
        resetn = 1'b1;
        z = mk(0, 0, 0, 0, 0, 0, 0, 0);
        hist.delete();
        hist.push_back(z);
        hist.push_back(z);
        cnt_m   = 0;
        prev_vs = 1'b0;
    endtask

    vec_t        tbl [14];
    logic [11:0] r;
    logic        h;
    samp_t       s;
    samp_t       idle;

    initial begin
        n_chk  = 0;
        n_fail = 0;
        bus.px_x = '0; bus.px_y = '0; bus.de_in = 1'b0;
        bus.hsync_in = 1'b0; bus.vsync_in = 1'b0;
        bus.cursor_en = 1'b0; bus.cursor_col = '0; bus.cursor_row = '0;

        for (int i = 0; i < 4096; i++) ram[i] = 8'($urandom);
        for (int i = 0; i < 256; i++) font[i] = {$urandom, $urandom};
        font[8'h41] = 64'h183C_6666_7E66_6600;
        font[8'h20] = 64'h0;
        font[8'hFF] = {64{1'b1}};
        ram[0]  = 8'h41;
        ram[1]  = 8'hFF;
        ram[80] = 8'hFF;
        ram[82] = 8'h20;
        idle = mk(0, 0, 0, 0, 0, 0, 0, 0);

        do_reset(3);

        tbl[0]  = '{0, 0, 1'b1, BG};
        tbl[1]  = '{1, 0, 1'b1, BG};
        tbl[2]  = '{2, 0, 1'b1, BG};
        tbl[3]  = '{3, 0, 1'b1, FG};
        tbl[4]  = '{4, 0, 1'b1, FG};
        tbl[5]  = '{5, 0, 1'b1, BG};
        tbl[6]  = '{6, 0, 1'b1, BG};
        tbl[7]  = '{7, 0, 1'b1, BG};
        tbl[8]  = '{3, 0, 1'b0, 12'h000};
        tbl[9]  = '{640, 0, 1'b1, BG};
        tbl[10] = '{10, 0, 1'b1, FG};
        tbl[11] = '{10, 0, 1'b0, 12'h000};
        tbl[12] = '{2, 1, 1'b1, FG};
        tbl[13] = '{0, 1, 1'b1, BG};
        for (int i = 0; i < 16; i++) begin
            if (i < 14) s = mk(tbl[i].px, tbl[i].py, tbl[i].de, (i % 2) == 1, 1'b0, 1'b0, 0, 0);
            else        s = idle;
            step(s, r, h);
            if (i >= 2) check("tbl_rgb", 64'(r), 64'(tbl[i-2].exp));
        end

        step(mk(637, 479, 1'b1, 1'b0, 1'b0, 1'b0, 0, 0), r, h);
        check("tx_addr_637_479", 64'(bus.tx_addr), 64'((59 * 80 + 79) % 4096));
        step(idle, r, h);
        step(idle, r, h);

        probe(mk(10, 0, 1'b0, 1'b1, 1'b0, 1'b0, 0, 0), r, h);
        check("de_low_rgb", 64'(r), 64'h0);
        check("de_low_hsync", 64'(h), 64'h1);

        do_reset(2);
        for (int f = 0; f < 34; f++) begin
            probe(mk(16 + f % 8, 14 + f % 2, 1'b1, 1'b0, 1'b0, 1'b1, 2, 1), r, h);
            check("cursor_row67", 64'(r), 64'(((f % 32) >= 16) ? FG : BG));
            probe(mk(17, 8 + f % 6, 1'b1, 1'b0, 1'b0, 1'b1, 2, 1), r, h);
            check("cursor_row0_5", 64'(r), 64'(BG));
            step(mk(0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0), r, h);
            if (f == 5) begin
                for (int k = 0; k < 10; k++) step(mk(0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0, 0), r, h);
            end
            step(idle, r, h);
        end

        for (int i = 0; i < 600; i++) begin
            int px, py;
            px = int'($urandom_range(0, 1023));
            py = int'($urandom_range(0, 1023));
            if ($urandom_range(0, 1) == 1) begin
                px = int'($urandom_range(0, 700));
                py = int'($urandom_range(0, 520));
            end
            s = mk(px, py, 1'($urandom), 1'($urandom), ($urandom_range(0, 5) == 0),
                   1'($urandom), 0, 0);
            if ($urandom_range(0, 1) == 1) begin
                s.ccol = (px / 8) % 128;
                s.crow = (py / 8) % 32;
            end else begin
                s.ccol = int'($urandom_range(0, 127));
                s.crow = int'($urandom_range(0, 31));
            end
            step(s, r, h);
            if (i == 300) do_reset(2);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
